fsm_seq_ctrl: RTL

FSM_SEQ_CTRL -- requirements
Module: fsm_seq_ctrl

---
 rtl/fsm_seq_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fsm_seq_ctrl.sv
// rtl/fsm_seq_ctrl.sv - word-to-serial sequencer that counts detector hits
//
// Purpose:
//   Accepts a WIDTH-bit word and shifts it MSB first into an external
//   detector FSM, one bit per cycle. It then allows one drain cycle so the
//   detector's registered output can catch up. Every detector hit is counted
//   and the count is presented with a valid/ready handshake.
//   The detector is held in reset whenever no word is in flight, so no
//   detection can be carried from one word into the next.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   in_word valid
//   in_ready   out  controller accepts a word (IDLE only)
//   in_word    in   WIDTH-bit word, shifted out MSB first
//   det_rst    out  synchronous reset to the detector FSM
//   det_inp    out  serial bit to the detector FSM
//   det_out    in   registered detector output (one cycle behind det_inp)
//   out_valid  out  out_count is valid
//   out_ready  in   consumer takes the result
//   out_count  out  detections in the word (0 while out_valid=0)
//   busy       out  high in every state except IDLE
//
// Configuration:
//   COUNT_SAT_EN  defined: the count saturates at 2^CW-1
//                 undefined: the count wraps modulo 2^CW

module fsm_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_word,
  output logic             det_rst,
  output logic             det_inp,
  input  logic             det_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int             IW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_MAX  = '1;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [IW-1:0]    r_idx;
  logic [CW-1:0]    r_count;

  logic             w_sample;
  logic [CW-1:0]    w_count_nxt;

  // det_out in SHIFT cycle 0 still reflects the reset state of the detector,
  // so it is skipped; the drain cycle carries the result of the last bit.
  assign w_sample = det_out &
                    (((r_state == S_SHIFT) && (r_idx != '0)) || (r_state == S_DRAIN));

`ifdef COUNT_SAT_EN
  assign w_count_nxt = (r_count == CNT_MAX) ? r_count : r_count + CW'(1);
`else
  assign w_count_nxt = r_count + CW'(1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_shift <= in_word;
            r_idx   <= '0;
            r_count <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_shift <= {r_shift[WIDTH-2:0], 1'b0};
          if (w_sample) begin
            r_count <= w_count_nxt;
          end
          if (r_idx == LAST_IDX) begin
            r_state <= S_DRAIN;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        S_DRAIN: begin
          if (w_sample) begin
            r_count <= w_count_nxt;
          end
          r_state <= S_DONE;
        end
        S_DONE: begin
          // No bypass to a new word here: the next acceptance happens in IDLE.
          if (out_ready) begin
            r_count <= '0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_count = out_valid ? r_count : '0;

  // rst reaches det_rst combinationally so the detector is cleared on the
  // same edge as the controller.
  assign det_rst = rst | (r_state == S_IDLE) | (r_state == S_DONE);
  assign det_inp = ~rst & (r_state == S_SHIFT) & r_shift[WIDTH-1];

endmodule
